hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Drives the ForwardA/ForwardB selects consumed by the EX stage and the stall/flush controls for IF/ID,
//  ID/EX and EX/MEM. Internally shadows the destination/read-register fields of EX, MEM and WB.
//  Resolves RAW hazards by forwarding (EX/MEM over MEM/WB), a 1-cycle load-use stall, and a
//  branch/jump flush. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W   16   width of StallCount and FlushCount (saturating)
// PORTS
//  clk            in   1      pipeline clock, all state on posedge
//  reset          in   1      asynchronous, active-high; clears all state
//  RsAddr_id      in   5      rs field of instruction in ID
//  RtAddr_id      in   5      rt field of instruction in ID
//  UsesRs_id      in   1      ID instruction reads rs
//  UsesRt_id      in   1      ID instruction reads rt (R-type, store, beq)
//  RegWriteAddr_ex in  5      destination selected by the EX RegDst mux
//  RegWrite_ex    in   1      EX instruction writes the register file
//  MemRead_ex     in   1      EX instruction is a load
//  Branch_taken   in   1      branch/jump redirect resolved this cycle (MEM stage)
//  ForwardA       out  2      00 RsData_ex, 01 reg_data_wb, 10 alu_res_mem
//  ForwardB       out  2      same encoding for the rt operand
//  PC_Write       out  1      0 = hold PC
//  IFID_Write     out  1      0 = hold IF/ID
//  IFID_Flush     out  1      1 = IF/ID loads NOP
//  IDEX_Flush     out  1      1 = ID/EX loads bubble (all control 0)
//  EXMEM_Flush    out  1      1 = EX/MEM loads bubble
//  StallCount     out  CNT_W  cycles with load-use stall
//  FlushCount     out  CNT_W  cycles with Branch_taken
// BEHAVIOUR
//  Shadow regs, all reset to 0:
//    rs_ex, rt_ex, mem_dst, mem_we, wb_dst, wb_we.
//  Posedge update:
//    rs_ex/rt_ex <= IDEX_Flush ? 0 : (UsesRs_id ? RsAddr_id : 0) / (UsesRt_id ? RtAddr_id : 0).
//    mem_dst/mem_we <= EXMEM_Flush ? 0/0 : RegWriteAddr_ex/RegWrite_ex.
//    wb_dst/wb_we <= mem_dst/mem_we (never flushed).
//  Forwarding (combinational from the shadow regs):
//    ForwardA = 10 if mem_we & mem_dst!=0 & mem_dst==rs_ex;
//               else 01 if wb_we & wb_dst!=0 & wb_dst==rs_ex;
//               else 00.
//    ForwardB: same rule with rt_ex. MEM beats WB when both match. Register $0 never forwards.
//  Load-use:
//    lu = MemRead_ex & RegWrite_ex & RegWriteAddr_ex!=0 &
//         ((UsesRs_id & ==RsAddr_id) | (UsesRt_id & ==RtAddr_id)).
//    lu forces PC_Write=0, IFID_Write=0, IDEX_Flush=1 for exactly that cycle. The next cycle the load
//    is in MEM and the bubble in EX, so the following cycle supplies the value via ForwardX=01.
//  Branch: Branch_taken forces IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, PC_Write=1, IFID_Write=1.
//    Branch overrides lu in the same cycle: no stall, and StallCount is not incremented.
//  Idle (no lu, no branch): PC_Write=IFID_Write=1, all flushes 0.
//  Counters:
//    StallCount += 1 on cycles with lu & ~Branch_taken.
//    FlushCount += 1 on cycles with Branch_taken.
//    Both saturate at all-ones and do not wrap.
//  Reset:
//    While reset=1, ForwardA/B=00, PC_Write=IFID_Write=1, all flushes 0, counters 0.
//    Asserting reset mid-stall drops the stall immediately (asynchronously).
//    The first edge after deassertion behaves as idle with empty shadows.
//  Latency: all outputs are combinational from current inputs plus the shadow regs; no added cycles.
// TESTING
//  1. add $3 (EX), then sub reading $3 next cycle -> ForwardA=10 in that EX cycle; with an intervening
//     nop -> ForwardA=01.
//  2. $5 written by both MEM and WB instrs, EX reads $5 as rt -> ForwardB=10. Destination $0 -> 00.
//  3. lw $2 in EX, ID reads $2 via rs -> exactly 1 cycle PC_Write=0, IFID_Write=0, IDEX_Flush=1;
//     2 cycles later ForwardA=01; StallCount=1.
//  4. lu and Branch_taken in the same cycle -> no stall, all three flushes 1; the next EX cycle shows
//     ForwardA/B=00 for the flushed ops; FlushCount=1, StallCount=0.
//  5. CNT_W=4, 20 consecutive load-use cycles -> StallCount holds at 15.
//  6. reset pulsed mid-stall (between clock edges) -> PC_Write=1 immediately, counters 0,
//     shadows cleared.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding, load-use stall, branch flush and saturating stall/flush counters
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsAddr_id,
  input  logic [4:0]       RtAddr_id,
  input  logic             UsesRs_id,
  input  logic             UsesRt_id,
  input  logic [4:0]       RegWriteAddr_ex,
  input  logic             RegWrite_ex,
  input  logic             MemRead_ex,
  input  logic             Branch_taken,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  logic [4:0] rs_ex, rt_ex, mem_dst, wb_dst;
  logic       mem_we, wb_we, lu, br, stall;
  // reset gates the controls so a stall in progress drops without waiting for a clock
  assign br    = Branch_taken & ~reset;
  assign lu    = ~reset & MemRead_ex & RegWrite_ex & (RegWriteAddr_ex != 5'd0) &
                 ((UsesRs_id & (RegWriteAddr_ex == RsAddr_id)) | (UsesRt_id & (RegWriteAddr_ex == RtAddr_id)));
  assign stall = lu & ~br;
  assign PC_Write    = ~stall;
  assign IFID_Write  = ~stall;
  assign IFID_Flush  = br;
  assign IDEX_Flush  = stall | br;
  assign EXMEM_Flush = br;
  always_comb begin
    ForwardA = (mem_we && mem_dst != 5'd0 && mem_dst == rs_ex) ? 2'b10 :
               (wb_we && wb_dst != 5'd0 && wb_dst == rs_ex) ? 2'b01 : 2'b00;
    ForwardB = (mem_we && mem_dst != 5'd0 && mem_dst == rt_ex) ? 2'b10 :
               (wb_we && wb_dst != 5'd0 && wb_dst == rt_ex) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_ex      <= '0;
      rt_ex      <= '0;
      mem_dst    <= '0;
      mem_we     <= 1'b0;
      wb_dst     <= '0;
      wb_we      <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      rs_ex      <= (IDEX_Flush || !UsesRs_id) ? 5'd0 : RsAddr_id;
      rt_ex      <= (IDEX_Flush || !UsesRt_id) ? 5'd0 : RtAddr_id;
      mem_dst    <= EXMEM_Flush ? 5'd0 : RegWriteAddr_ex;
      mem_we     <= EXMEM_Flush ? 1'b0 : RegWrite_ex;
      wb_dst     <= mem_dst;
      wb_we      <= mem_we;
      StallCount <= (stall && StallCount != '1) ? StallCount + 1'b1 : StallCount;
      FlushCount <= (br && FlushCount != '1) ? FlushCount + 1'b1 : FlushCount;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed pipeline table, corner sequences and random run against a stage-list model
module tb_hazard_forward_unit;
  localparam int W = 4;
  logic clk = 1'b0, reset;
  logic [4:0] RsAddr_id, RtAddr_id, RegWriteAddr_ex;
  logic UsesRs_id, UsesRt_id, RegWrite_ex, MemRead_ex, Branch_taken;
  logic [1:0] ForwardA, ForwardB;
  logic PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic [W-1:0] StallCount, FlushCount;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hazard_forward_unit #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .UsesRs_id(UsesRs_id), .UsesRt_id(UsesRt_id), .RegWriteAddr_ex(RegWriteAddr_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .Branch_taken(Branch_taken),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .StallCount(StallCount), .FlushCount(FlushCount));
  typedef struct {
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] wd;
    logic we, mr, bt;
    logic [1:0] fa, fb;
    logic [4:0] ctl;
  } vec_t;
  vec_t tbl[$];
  localparam logic [4:0] IDLE = 5'b11000, LU = 5'b00010, BR = 5'b11111;
  // model: EX read registers, then writers in MEM and WB, youngest first
  int ex_rs = 0, ex_rt = 0, sc = 0, fc = 0;
  int wr_d[2] = '{0, 0};
  bit wr_w[2] = '{0, 0};
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic add(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic [4:0] wd,
                     logic we, logic mr, logic bt, logic [1:0] fa, logic [1:0] fb, logic [4:0] ctl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.wd = wd; v.we = we; v.mr = mr; v.bt = bt;
    v.fa = fa; v.fb = fb; v.ctl = ctl;
    tbl.push_back(v);
  endtask
  task automatic drive(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic [4:0] wd,
                       logic we, logic mr, logic bt);
    RsAddr_id = rs; RtAddr_id = rt; UsesRs_id = urs; UsesRt_id = urt;
    RegWriteAddr_ex = wd; RegWrite_ex = we; MemRead_ex = mr; Branch_taken = bt;
  endtask
  task automatic chk_out(string n, logic [1:0] fa, logic [1:0] fb, logic [4:0] ctl);
    chk({n, " ForwardA"}, ForwardA, fa);
    chk({n, " ForwardB"}, ForwardB, fb);
    chk({n, " ctl"}, {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush}, ctl);
  endtask
  function automatic logic [1:0] fwd(int r);
    for (int k = 0; k < 2; k++)
      if (r != 0 && wr_w[k] && wr_d[k] == r) return k == 0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  initial begin
    reset = 1'b1;
    drive(2, 0, 1, 0, 2, 1, 1, 1);
    #1;
    chk_out("reset", 2'b00, 2'b00, IDLE);
    chk("reset StallCount", StallCount, 0);
    chk("reset FlushCount", FlushCount, 0);
    @(negedge clk);
    reset = 1'b0;
    add(1,2,1,1, 0,0,0,0, 0,0,IDLE);
    add(3,1,1,1, 3,1,0,0, 0,0,IDLE);
    add(0,0,0,0, 4,1,0,0, 2,0,IDLE);
    add(1,2,1,1, 0,0,0,0, 0,0,IDLE);
    add(0,0,0,0, 3,1,0,0, 0,0,IDLE);
    add(3,1,1,1, 0,0,0,0, 0,0,IDLE);
    add(0,0,0,0, 4,1,0,0, 1,0,IDLE);
    add(1,0,1,0, 0,0,0,0, 0,0,IDLE);
    add(1,0,1,0, 5,1,0,0, 0,0,IDLE);
    add(1,5,1,1, 5,1,0,0, 0,0,IDLE);
    add(0,0,0,0, 6,1,0,0, 0,2,IDLE);
    add(0,0,1,1, 0,1,0,0, 0,0,IDLE);
    add(0,0,0,0, 7,1,0,0, 0,0,IDLE);
    add(2,2,1,1, 2,1,1,1, 0,0,BR);
    add(0,0,0,0, 0,0,0,0, 0,0,IDLE);
    add(1,0,1,0, 0,0,0,0, 0,0,IDLE);
    add(2,3,1,1, 2,1,1,0, 0,0,LU);
    add(2,3,1,1, 0,0,0,0, 0,0,IDLE);
    add(0,0,0,0, 4,1,0,0, 1,0,IDLE);
    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wd, tbl[i].we, tbl[i].mr, tbl[i].bt);
      #1;
      chk_out($sformatf("row%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].ctl);
      @(negedge clk);
    end
    chk("table StallCount", StallCount, 1);
    chk("table FlushCount", FlushCount, 1);
    for (int i = 0; i < 20; i++) begin
      drive(9, 0, 1, 0, 9, 1, 1, 0);
      @(negedge clk);
    end
    chk("stall saturate", StallCount, 15);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
    end
    chk("flush saturate", FlushCount, 15);
    chk("stall held", StallCount, 15);
    drive(9, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(9, 0, 1, 0, 9, 1, 0, 0);
    @(negedge clk);
    drive(9, 0, 1, 0, 9, 1, 1, 0);
    #1;
    chk_out("pre-reset stall", 2'b10, 2'b00, LU);
    #1 reset = 1'b1;
    #1;
    chk_out("mid-stall reset", 2'b00, 2'b00, IDLE);
    chk("mid-stall StallCount", StallCount, 0);
    chk("mid-stall FlushCount", FlushCount, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_out("post-reset", 2'b00, 2'b00, IDLE);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rs, rt, wd;
      logic urs, urt, we, mr, bt, stall;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); wd = 5'($urandom_range(0, 3));
      urs = 1'($urandom_range(0, 1)); urt = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 3) != 0);
      mr = 1'($urandom_range(0, 2) == 0); bt = 1'($urandom_range(0, 7) == 0);
      drive(rs, rt, urs, urt, wd, we, mr, bt);
      stall = mr && we && wd != 0 && ((urs && rs == wd) || (urt && rt == wd)) && !bt;
      #1;
      chk_out($sformatf("rand%0d", i), fwd(ex_rs), fwd(ex_rt), {!stall, !stall, bt, stall || bt, bt});
      chk($sformatf("rand%0d StallCount", i), StallCount, sc);
      chk($sformatf("rand%0d FlushCount", i), FlushCount, fc);
      @(negedge clk);
      wr_d[1] = wr_d[0]; wr_w[1] = wr_w[0];
      wr_d[0] = bt ? 0 : int'(wd); wr_w[0] = bt ? 1'b0 : we;
      ex_rs = (stall || bt || !urs) ? 0 : int'(rs);
      ex_rt = (stall || bt || !urt) ? 0 : int'(rt);
      sc = (stall && sc < 15) ? sc + 1 : sc;
      fc = (bt && fc < 15) ? fc + 1 : fc;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
